vga_timing_ctrl: RTL
====================

// Module: vga_timing_ctrl
// PURPOSE
//  Generates 640x480@60Hz VGA timing from the 100 MHz system clock: pixel-tick divider,
//  horizontal/vertical counters, sync pulses and the active-video flag. Drives h_cnt/v_cnt
//  into the pixel address generator and takes back pixel data from frame/sprite memory.
//  Re-aligns hsync/vsync/valid to the memory read latency and registers the colour outputs.
// PARAMETERS
//  CLK_DIV  4    system clocks per pixel (100 MHz -> 25 MHz)
//  H_DISP   640  visible pixels per line
//  H_FP     16   horizontal front porch, pixels
//  H_SYNC   96   hsync pulse width, pixels
//  H_BP     48   horizontal back porch, pixels
//  V_DISP   480  visible lines per frame
//  V_FP     10   vertical front porch, lines
//  V_SYNC   2    vsync pulse width, lines
//  V_BP     33   vertical back porch, lines
//  RD_LAT   1    pixel-memory read latency in clk cycles, legal 0..3
// PORTS
//  clk          in   1   system clock, 100 MHz
//  rst          in   1   asynchronous, active-low reset
//  h_cnt        out  10  horizontal counter, 0..H_TOTAL-1 (to address generator)
//  v_cnt        out  10  vertical counter, 0..V_TOTAL-1 (to address generator)
//  pix_tick     out  1   one-clk strobe, once per pixel period
//  frame_start  out  1   one-clk strobe as counters wrap from (H_TOTAL-1,V_TOTAL-1) to (0,0)
//  rgb_in       in   12  pixel data from memory, {R4,G4,B4}, valid RD_LAT clks after address
//  vga_rgb      out  12  registered colour to DAC, forced 0 outside active video
//  hsync        out  1   horizontal sync, active-low
//  vsync        out  1   vertical sync, active-low
// BEHAVIOUR
//  - H_TOTAL = H_DISP+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525).
//  - Reset (rst low, async): div counter, h_cnt, v_cnt = 0; pix_tick, frame_start = 0;
//    vga_rgb = 0; hsync = vsync = 1; all delay-line stages = inactive (sync 1, valid 0).
//  - Divider: div counts 0..CLK_DIV-1 every clk and wraps; pix_tick = (div == CLK_DIV-1), registered.
//  - Counters advance only on clk edges where pix_tick is 1.
//    h_cnt == H_TOTAL-1 -> h_cnt = 0 and v_cnt increments; v_cnt == V_TOTAL-1 on same event -> 0.
//  - frame_start: 1 for the single clk following the (H_TOTAL-1,V_TOTAL-1)->(0,0) wrap.
//  - Raw timing, combinational from counters:
//    hs_raw = 0 iff H_DISP+H_FP <= h_cnt < H_DISP+H_FP+H_SYNC (656..751);
//    vs_raw = 0 iff V_DISP+V_FP <= v_cnt < V_DISP+V_FP+V_SYNC (490..491);
//    act_raw = (h_cnt < H_DISP) && (v_cnt < V_DISP).
//  - Alignment: {hs_raw, vs_raw, act_raw} pass through an RD_LAT-stage clk delay line.
//    RD_LAT = 0 is a straight wire.
//  - Output register, every clk: hsync/vsync <= delayed syncs;
//    vga_rgb <= delayed act ? rgb_in : 12'h000.
//  - Latency: pins reflect a counter value RD_LAT+1 clks after the counters take it.
//    rgb_in sampled for an address is exactly the one returned for that address.
//  - No handshake; free-running. Counter widths are fixed at 10 bits.
//    Parameter sets with totals > 1024 are illegal (elaboration-time check).
//  - Reset mid-frame: immediate return to reset values.
//    First pix_tick CLK_DIV clks after release; timing restarts at (0,0).
// STRUCTURE
//  - vga_pkg: default timing constants, derived H_TOTAL/V_TOTAL/sync start-end localparams,
//    and the RGB width (12).
//  - One sub-module, vga_delay_line #(WIDTH, DEPTH): async active-low reset shift register
//    with a per-bit reset value. Instantiated with WIDTH=3, DEPTH=RD_LAT.
//  - Top holds divider, counters, raw decode and the output register.
// TESTING
//  - Hold rst low, toggle clk -> hsync=vsync=1, vga_rgb=0, h_cnt=v_cnt=0, pix_tick=0.
//  - Release reset, count clks -> pix_tick every 4 clk; hsync period 3200 clk, low 384 clk;
//    falling edge RD_LAT+1 clk after h_cnt becomes 656.
//  - Run one full frame -> frame_start period 1,680,000 clk; vsync low 6400 clk;
//    exactly 307,200 pixels with nonzero-gated output per frame.
//  - Memory model returns rgb_in = {h_cnt[3:0],v_cnt[3:0],4'hA} with RD_LAT=1 and again
//    with RD_LAT=2 -> every active vga_rgb matches its pixel; vga_rgb=0 for h>=640 or v>=480.
//  - Check corner (639,479) visible then (640,479) blank; wrap (799,524)->(0,0) on one pix_tick
//    -> frame_start asserted once.
//  - Assert rst at h_cnt=300, v_cnt=200 -> outputs reset asynchronously within the same clk;
//    after release, counting restarts at (0,0) with the first pix_tick after 4 clk.

Source files
------------

// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
//   Shared constants for the VGA timing block: the default 640x480@60Hz timing
//   set (100 MHz system clock, 25 MHz pixel rate), the derived line/frame
//   totals and sync window bounds, the counter and colour widths, and the
//   packed record that carries the per-pixel timing flags down the pipeline.
// -----------------------------------------------------------------------------
package vga_pkg;

  localparam int CNT_W = 10;  // h_cnt / v_cnt width, fixed
  localparam int RGB_W = 12;  // {R4,G4,B4}

  localparam int DEF_CLK_DIV = 4;
  localparam int DEF_H_DISP  = 640;
  localparam int DEF_H_FP    = 16;
  localparam int DEF_H_SYNC  = 96;
  localparam int DEF_H_BP    = 48;
  localparam int DEF_V_DISP  = 480;
  localparam int DEF_V_FP    = 10;
  localparam int DEF_V_SYNC  = 2;
  localparam int DEF_V_BP    = 33;
  localparam int DEF_RD_LAT  = 1;

  localparam int DEF_H_TOTAL      = DEF_H_DISP + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;  // 800
  localparam int DEF_V_TOTAL      = DEF_V_DISP + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;  // 525
  localparam int DEF_H_SYNC_START = DEF_H_DISP + DEF_H_FP;                          // 656
  localparam int DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC;                  // 752
  localparam int DEF_V_SYNC_START = DEF_V_DISP + DEF_V_FP;                          // 490
  localparam int DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC;                  // 492

  // Sync flags are active-low; vld marks active video.
  typedef struct packed {
    logic hs;
    logic vs;
    logic vld;
  } timing_t;

  // Idle value of a timing record: both syncs deasserted, no active video.
  localparam timing_t TIMING_IDLE = '{hs: 1'b1, vs: 1'b1, vld: 1'b0};

endpackage

// File: rtl/vga_delay_line.sv
// -----------------------------------------------------------------------------
// vga_delay_line
//   DEPTH-stage shift register with asynchronous active-low reset to a
//   per-bit reset value. DEPTH = 0 degenerates to a plain wire.
// Ports
//   clk      in   1      clock
//   rst      in   1      asynchronous reset, active-low
//   data     in   WIDTH  value entering the line
//   delayed  out  WIDTH  value leaving the line, DEPTH clocks later
// -----------------------------------------------------------------------------
module vga_delay_line #(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] delayed
);

  if (DEPTH == 0) begin : g_wire
    assign delayed = data;
  end else begin : g_pipe
    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
      end else begin
        stage[0] <= data;
        for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
    end

    assign delayed = stage[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_ctrl.sv
// -----------------------------------------------------------------------------
// vga_timing_ctrl
//   VGA timing generator: pixel-tick divider, horizontal/vertical counters,
//   sync and active-video decode, realignment of those flags to the pixel
//   memory read latency, and the registered colour/sync outputs.
// Ports
//   clk          in   1   system clock
//   rst          in   1   asynchronous reset, active-low
//   h_cnt        out  10  horizontal position, 0..H_TOTAL-1 (to address generator)
//   v_cnt        out  10  vertical position, 0..V_TOTAL-1 (to address generator)
//   pix_tick     out  1   one-clock strobe per pixel period
//   frame_start  out  1   one-clock strobe after the (last,last)->(0,0) wrap
//   rgb_in       in   12  pixel data from memory, RD_LAT clocks after address
//   vga_rgb      out  12  registered colour, zero outside active video
//   hsync        out  1   horizontal sync, active-low
//   vsync        out  1   vertical sync, active-low
// -----------------------------------------------------------------------------
module vga_timing_ctrl
  import vga_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV,
  parameter int H_DISP  = DEF_H_DISP,
  parameter int H_FP    = DEF_H_FP,
  parameter int H_SYNC  = DEF_H_SYNC,
  parameter int H_BP    = DEF_H_BP,
  parameter int V_DISP  = DEF_V_DISP,
  parameter int V_FP    = DEF_V_FP,
  parameter int V_SYNC  = DEF_V_SYNC,
  parameter int V_BP    = DEF_V_BP,
  parameter int RD_LAT  = DEF_RD_LAT
) (
  input  logic             clk,
  input  logic             rst,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt,
  output logic             pix_tick,
  output logic             frame_start,
  input  logic [RGB_W-1:0] rgb_in,
  output logic [RGB_W-1:0] vga_rgb,
  output logic             hsync,
  output logic             vsync
);

  localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_DISP);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_DISP);
  localparam logic [CNT_W-1:0] H_SS     = CNT_W'(H_DISP + H_FP);
  localparam logic [CNT_W-1:0] H_SE     = CNT_W'(H_DISP + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] V_SS     = CNT_W'(V_DISP + V_FP);
  localparam logic [CNT_W-1:0] V_SE     = CNT_W'(V_DISP + V_FP + V_SYNC);

  // The counters are 10 bits wide; larger timing sets cannot be represented.
  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
    $error("vga_timing_ctrl: H_TOTAL/V_TOTAL exceed 1024");
  end
  if (RD_LAT < 0 || RD_LAT > 3) begin : g_bad_lat
    $error("vga_timing_ctrl: RD_LAT must be 0..3");
  end
  if (CLK_DIV < 1) begin : g_bad_div
    $error("vga_timing_ctrl: CLK_DIV must be at least 1");
  end

  logic [DIV_W-1:0] div;
  timing_t          timing_p0;
  timing_t          timing_p1;

  // Divider: pix_tick is registered, so it rises one clock after div hits
  // its last value and the first tick lands CLK_DIV clocks after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div      <= '0;
      pix_tick <= 1'b0;
    end else begin
      div      <= (div == DIV_LAST) ? '0 : div + 1'b1;
      pix_tick <= (div == DIV_LAST);
    end
  end

  // Position counters, advancing once per pixel tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= pix_tick && (h_cnt == H_LAST) && (v_cnt == V_LAST);
      if (pix_tick) begin
        if (h_cnt == H_LAST) begin
          h_cnt <= '0;
          v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end else begin
          h_cnt <= h_cnt + 1'b1;
        end
      end
    end
  end

  // ---- stage p0: raw timing decoded from the counters ----
  always_comb begin
    timing_p0     = TIMING_IDLE;
    timing_p0.hs  = !((h_cnt >= H_SS) && (h_cnt < H_SE));
    timing_p0.vs  = !((v_cnt >= V_SS) && (v_cnt < V_SE));
    timing_p0.vld = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  end

  // ---- stage p1: timing delayed to line up with rgb_in for the same address ----
  vga_delay_line #(
    .WIDTH   ($bits(timing_t)),
    .DEPTH   (RD_LAT),
    .RST_VAL (TIMING_IDLE)
  ) u_align (
    .clk     (clk),
    .rst     (rst),
    .data    (timing_p0),
    .delayed (timing_p1)
  );

  // ---- output register: syncs and gated colour ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hsync   <= 1'b1;
      vsync   <= 1'b1;
      vga_rgb <= '0;
    end else begin
      hsync   <= timing_p1.hs;
      vsync   <= timing_p1.vs;
      vga_rgb <= timing_p1.vld ? rgb_in : '0;
    end
  end

endmodule
